// File: rtl/projectile.sv
// Ballistic flight stage: latches power/turn on throw_flag, steps the projectile once
// per frame_tick and reports target hit, landing or off-screen exit via end_throw.
// Optional feature: define PROJECTILE_WIND_EN to add the signed wind input that biases vx.
module projectile #(
  parameter int X_START_P1    = 100,
  parameter int X_START_P2    = 924,
  parameter int Y_START       = 500,
  parameter int GROUND_Y      = 700,
  parameter int SCREEN_W      = 1024,
  parameter int GRAVITY       = 1,
  parameter int TARGET_HALF_W = 16,
  parameter int TARGET_H      = 48
) (
  input  logic        clk60MHz,
  input  logic        rst,
  input  logic        throw_flag,
  input  logic [4:0]  power,
  input  logic        turn,
  input  logic        frame_tick,
`ifdef PROJECTILE_WIND_EN
  input  logic [3:0]  wind,
`endif
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic        active,
  output logic        end_throw,
  output logic        hit
);

  typedef enum logic [1:0] {IDLE, LAUNCH, FLY, DONE} state_t;

  localparam logic signed [12:0] P1_X    = 13'(X_START_P1);
  localparam logic signed [12:0] P2_X    = 13'(X_START_P2);
  localparam logic signed [12:0] Y0      = 13'(Y_START);
  localparam logic signed [12:0] GROUND  = 13'(GROUND_Y);
  localparam logic signed [12:0] SCR_MAX = 13'(SCREEN_W - 1);
  localparam logic signed [12:0] HALF    = 13'(TARGET_HALF_W);
  localparam logic signed [12:0] TGT_TOP = 13'(Y_START - TARGET_H);
  localparam logic signed [8:0]  GRAV    = 9'(GRAVITY);

  state_t             state, state_n;
  logic signed [12:0] x_q, x_n, y_q, y_n;
  logic        [4:0]  vx_q, vx_n, pwr_q, pwr_n;
  logic signed [7:0]  vy_q, vy_n;
  logic               dir_q, dir_n, turn_q, turn_n;
  logic               hit_q, hit_n, active_q, active_n, end_q, end_n;

  logic signed [12:0] vx_ext, vy_ext, x_step, y_step, x_clamp, opp_x;
  logic signed [8:0]  vy_sum;
  logic signed [7:0]  vy_sat;
  logic        [4:0]  launch_vx;
  logic               on_tgt, on_ground, off_scr;

  assign vx_ext = $signed({8'd0, vx_q});
  assign vy_ext = $signed({{5{vy_q[7]}}, vy_q});
  assign x_step = dir_q ? (x_q - vx_ext) : (x_q + vx_ext);
  assign y_step = y_q + vy_ext;
  assign vy_sum = $signed({vy_q[7], vy_q}) + GRAV;
  assign vy_sat = (vy_sum > 9'sd127) ? 8'sd127 : $signed(vy_sum[7:0]);

  // The opponent stands at the other player's launch x.
  assign opp_x     = dir_q ? P1_X : P2_X;
  assign on_tgt    = (x_step >= opp_x - HALF) && (x_step <= opp_x + HALF) && (y_step >= TGT_TOP);
  assign on_ground = (y_step >= GROUND);
  assign off_scr   = (x_step < 13'sd0) || (x_step > SCR_MAX);
  assign x_clamp   = (x_step < 13'sd0) ? 13'sd0 : ((x_step > SCR_MAX) ? SCR_MAX : x_step);

`ifdef PROJECTILE_WIND_EN
  logic signed [6:0] wind_ext, vx_wind;
  assign wind_ext  = $signed({{3{wind[3]}}, wind});
  assign vx_wind   = turn_q ? ($signed({2'b00, pwr_q}) - wind_ext)
                            : ($signed({2'b00, pwr_q}) + wind_ext);
  assign launch_vx = (vx_wind < 7'sd0) ? 5'd0 : ((vx_wind > 7'sd31) ? 5'd31 : vx_wind[4:0]);
`else
  assign launch_vx = pwr_q;
`endif

  always_comb begin
    state_n  = state;
    x_n      = x_q;
    y_n      = y_q;
    vx_n     = vx_q;
    vy_n     = vy_q;
    dir_n    = dir_q;
    pwr_n    = pwr_q;
    turn_n   = turn_q;
    hit_n    = hit_q;
    active_n = active_q;
    end_n    = end_q;
    case (state)
      IDLE: begin
        if (throw_flag) begin
          pwr_n   = power;
          turn_n  = turn;
          state_n = LAUNCH;
        end
      end
      LAUNCH: begin
        x_n      = turn_q ? P2_X : P1_X;
        y_n      = Y0;
        vx_n     = launch_vx;
        vy_n     = 8'sd0 - $signed({3'b000, pwr_q});
        dir_n    = turn_q;
        hit_n    = 1'b0;
        active_n = 1'b1;
        state_n  = FLY;
      end
      FLY: begin
        if (frame_tick) begin
          if (on_tgt || on_ground || off_scr) begin
            active_n = 1'b0;
            end_n    = 1'b1;
            state_n  = DONE;
          end
          if (on_tgt) begin
            hit_n = 1'b1;
            x_n   = x_step;
            y_n   = y_step;
          end else if (on_ground) begin
            hit_n = 1'b0;
            x_n   = x_clamp;
            y_n   = GROUND;
          end else if (off_scr) begin
            hit_n = 1'b0;
            x_n   = x_clamp;
            y_n   = y_step;
          end else begin
            x_n  = x_step;
            y_n  = y_step;
            vy_n = vy_sat;
          end
        end
      end
      DONE: begin
        if (!throw_flag) begin
          end_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk60MHz or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      vx_q     <= '0;
      vy_q     <= '0;
      dir_q    <= 1'b0;
      pwr_q    <= '0;
      turn_q   <= 1'b0;
      hit_q    <= 1'b0;
      active_q <= 1'b0;
      end_q    <= 1'b0;
    end else begin
      state    <= state_n;
      x_q      <= x_n;
      y_q      <= y_n;
      vx_q     <= vx_n;
      vy_q     <= vy_n;
      dir_q    <= dir_n;
      pwr_q    <= pwr_n;
      turn_q   <= turn_n;
      hit_q    <= hit_n;
      active_q <= active_n;
      end_q    <= end_n;
    end
  end

  // Above-screen positions are legal internally but render at row 0.
  assign x_pos     = x_q[11:0];
  assign y_pos     = y_q[12] ? 12'd0 : y_q[11:0];
  assign active    = active_q;
  assign end_throw = end_q;
  assign hit       = hit_q;

endmodule

// File: tb/tb_projectile.sv
// Scoreboard bench for projectile: directed throws push expected landings, a monitor
// compares them when end_throw rises; reset and handshake are checked inline.
module tb_projectile;

  logic        clk60MHz = 1'b0;
  logic        rst = 1'b0;
  logic        throw_flag = 1'b0;
  logic [4:0]  power = '0;
  logic        turn = 1'b0;
  logic        frame_tick = 1'b0;
  logic [3:0]  wind = '0;
  logic [11:0] x_pos, y_pos;
  logic        active, end_throw, hit;

  projectile dut (
    .clk60MHz   (clk60MHz),
    .rst        (rst),
    .throw_flag (throw_flag),
    .power      (power),
    .turn       (turn),
    .frame_tick (frame_tick),
`ifdef PROJECTILE_WIND_EN
    .wind       (wind),
`endif
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .active     (active),
    .end_throw  (end_throw),
    .hit        (hit)
  );

  always #5 clk60MHz = ~clk60MHz;

  typedef struct {
    int x;
    int y;
    int h;
    int n;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   ticks = 0;
  logic end_seen = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk60MHz) begin
    if (end_throw && !end_seen) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_end", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("final_x", int'(x_pos), e.x);
        chk("final_y", int'(y_pos), e.y);
        chk("final_hit", int'(hit), e.h);
        chk("tick_count", ticks, e.n);
      end
    end
    end_seen = end_throw;
  end

  task automatic step();
    @(posedge clk60MHz);
    #1;
  endtask

  task automatic wait_active(output bit ok);
    int n = 0;
    while (!active && n < 10) begin
      step();
      n++;
    end
    ok = active;
  endtask

  task automatic fly(input logic [4:0] p, input logic t, input int ex, input int ey,
                     input int eh, input int en, input int hold);
    bit ok;
    int n;
    logic was;
    sb_q.push_back('{ex, ey, eh, en});
    power = p;
    turn = t;
    throw_flag = 1'b1;
    ticks = 0;
    wait_active(ok);
    if (!ok) begin
      chk("launch_timeout", 0, 1);
      void'(sb_q.pop_back());
      throw_flag = 1'b0;
      step();
      return;
    end
    chk("hit_clear_at_launch", int'(hit), 0);
    // Inputs after launch must not affect the flight.
    power = ~p;
    turn = ~t;
    n = 0;
    while (!end_throw && n < 200) begin
      frame_tick = 1'b1;
      was = active;
      step();
      frame_tick = 1'b0;
      if (was) ticks++;
      step();
      n++;
    end
    if (!end_throw) begin
      chk("flight_timeout", 0, 1);
      void'(sb_q.pop_back());
    end
    for (int i = 0; i < hold; i++) begin
      step();
      chk("end_held", int'(end_throw), 1);
      chk("no_relaunch", int'(active), 0);
    end
    throw_flag = 1'b0;
    chk("end_before_drop", int'(end_throw), 1);
    step();
    chk("end_fall", int'(end_throw), 0);
    step();
  endtask

  initial begin
    bit ok;
    #12;
    chk("rst_x", int'(x_pos), 0);
    chk("rst_y", int'(y_pos), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_end", int'(end_throw), 0);
    chk("rst_hit", int'(hit), 0);
    rst = 1'b1;
    step();

    // Reset mid-flight
    power = 5'd10;
    turn = 1'b0;
    throw_flag = 1'b1;
    wait_active(ok);
    chk("midrst_launched", int'(active), 1);
    for (int i = 0; i < 5; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
    #3 rst = 1'b0;
    #1;
    chk("midrst_x", int'(x_pos), 0);
    chk("midrst_y", int'(y_pos), 0);
    chk("midrst_active", int'(active), 0);
    chk("midrst_end", int'(end_throw), 0);
    chk("midrst_hit", int'(hit), 0);
    throw_flag = 1'b0;
    step();
    rst = 1'b1;
    step();
    step();
    chk("postrst_idle_active", int'(active), 0);

    fly(5'd10, 1'b0, 440, 700, 0, 34, 0);
    fly(5'd10, 1'b1, 584, 700, 0, 34, 0);
    fly(5'd20, 1'b0, 920, 500, 1, 41, 0);
    fly(5'd31, 1'b0, 1023, 5, 0, 30, 0);
    fly(5'd0,  1'b0, 100, 700, 0, 21, 5);

    repeat (4) step();
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
